// File: rtl/div32.sv
// Restoring 32-bit signed/unsigned divider: one quotient bit per clock, trial subtraction via add32.
// Latency: done 33 edges after start (1 for divide-by-zero); start is ignored while busy.

module add32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             carry;

    always_comb begin
        g     = a_i & b_i;
        p     = a_i ^ b_i;
        carry = cin_i;
        sum_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = p[i] ^ carry;
            carry    = g[i] | (p[i] & carry);
        end
        cout_o = carry;
    end
endmodule

module div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;
    logic             trial_co;
    logic             accept;

    assign shifted = {rem_q, dvd_q[WIDTH-1]};

    add32 #(.WIDTH(WIDTH)) u_sub (
        .a_i    (shifted[WIDTH-1:0]),
        .b_i    (~dvs_q),
        .cin_i  (1'b1),
        .sum_o  (trial),
        .cout_o (trial_co)
    );

    // A set bit 32 means the shifted remainder already exceeds any 32-bit divisor.
    assign accept = trial_co | shifted[WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    q_neg_d = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d = signed_op & dividend[WIDTH-1];
                    rem_d   = '0;
                    cnt_d   = '0;
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        dvd_d   = dividend;
                        state_d = FIXUP;
                    end else begin
                        dz_d    = 1'b0;
                        dvd_d   = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
                        dvs_d   = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
                        state_d = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                rem_d = accept ? trial : shifted[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], accept};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dz_q) begin
                    quo_d  = '1;
                    remo_d = dvd_q;
                    dbz_d  = 1'b1;
                end else begin
                    quo_d  = q_neg_q ? -dvd_q : dvd_q;
                    remo_d = r_neg_q ? -rem_q : rem_q;
                    dbz_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            remo_q  <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;
endmodule
